// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer that drives a shared 8-bit add/subtract
// ALU. It performs 16-bit ADD/SUB/CMP as two byte passes (low byte, then high
// byte) and 8x8 unsigned MUL by shift-and-add. Requests and results use a
// start/ready/done handshake.
module alu_seq_ctrl #(
    parameter int unsigned BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [2*BYTE_W-1:0]   opa,
    input  logic [2*BYTE_W-1:0]   opb,
    output logic                  ready,
    output logic                  done,
    output logic [2*BYTE_W-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic [BYTE_W-1:0]     alu_a,
    output logic [BYTE_W-1:0]     alu_b,
    output logic                  alu_cin,
    input  logic [BYTE_W-1:0]     alu_result,
    input  logic                  alu_cout
);

    localparam int unsigned W  = 2 * BYTE_W;
    localparam int unsigned IW = $clog2(BYTE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    state_t            state;
    op_t               op_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [BYTE_W-1:0] lo;
    logic              c_lo;
    logic [BYTE_W-1:0] acc_hi;
    logic [BYTE_W-1:0] acc_lo;
    logic [IW-1:0]     iter;

    op_t               op_in;
    logic              in_sub;
    logic              is_sub;
    logic              hi_flag;
    logic [W-1:0]      word16;
    logic [BYTE_W-1:0] mul_hi_n;
    logic [BYTE_W-1:0] mul_lo_n;
    logic [W-1:0]      product;

    // Decode helpers and next-value terms derived from the live ALU response.
    always_comb begin
        op_in    = op_t'(op);
        in_sub   = (op_in == OP_SUB) || (op_in == OP_CMP);
        is_sub   = (op_r == OP_SUB) || (op_r == OP_CMP);
        // High-byte pass: the ALU cout inverts meaning when the B byte was
        // complemented, so xor with the low-byte carry/borrow restores it.
        hi_flag  = alu_cout ^ c_lo;
        word16   = {alu_result, lo};
        mul_hi_n = {alu_cout, alu_result[BYTE_W-1:1]};
        mul_lo_n = {alu_result[0], acc_lo[BYTE_W-1:1]};
        product  = {mul_hi_n, mul_lo_n};
    end

    // Sequencer FSM. ALU drive registers are loaded on the edge entering each
    // state, so they hold the values required during that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op_r    <= OP_ADD;
            a_r     <= '0;
            b_r     <= '0;
            lo      <= '0;
            c_lo    <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            iter    <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_cin <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r  <= op_in;
                        a_r   <= opa;
                        b_r   <= opb;
                        ready <= 1'b0;
                        if (op_in == OP_MUL) begin
                            state   <= S_MUL;
                            acc_hi  <= '0;
                            acc_lo  <= opb[BYTE_W-1:0];
                            iter    <= '0;
                            alu_a   <= '0;
                            alu_b   <= opb[0] ? opa[BYTE_W-1:0] : '0;
                            alu_cin <= 1'b0;
                        end else begin
                            state   <= S_LO;
                            alu_a   <= opa[BYTE_W-1:0];
                            alu_b   <= opb[BYTE_W-1:0];
                            alu_cin <= in_sub;
                        end
                    end
                end

                S_LO: begin
                    lo      <= alu_result;
                    c_lo    <= alu_cout;
                    state   <= S_HI;
                    alu_a   <= a_r[W-1:BYTE_W];
                    // Propagate carry/borrow using only the ALU's two modes:
                    // complementing B and flipping the mode folds in the +1/-1.
                    alu_b   <= alu_cout ? ~b_r[W-1:BYTE_W] : b_r[W-1:BYTE_W];
                    alu_cin <= is_sub ^ alu_cout;
                end

                S_HI: begin
                    if (op_r != OP_CMP) begin
                        result <= word16;
                    end
                    carry   <= hi_flag;
                    zero    <= (word16 == '0);
                    done    <= 1'b1;
                    state   <= S_DONE;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_cin <= 1'b0;
                end

                S_MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    iter   <= iter + 1'b1;
                    if (iter == IW'(BYTE_W - 1)) begin
                        result  <= product;
                        carry   <= 1'b0;
                        zero    <= (product == '0);
                        done    <= 1'b1;
                        state   <= S_DONE;
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_cin <= 1'b0;
                    end else begin
                        alu_a   <= mul_hi_n;
                        alu_b   <= mul_lo_n[0] ? a_r[BYTE_W-1:0] : '0;
                        alu_cin <= 1'b0;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_cin <= 1'b0;
                end
            endcase
        end
    end

endmodule
